// File: rtl/miss_pkg.sv
// Shared types and constants for the miss bookkeeping stage.
package miss_pkg;

  localparam int unsigned MISS_W = 2;
  localparam logic [MISS_W-1:0] MAX_MISS = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    OVER = 2'd2
  } miss_state_t;

endpackage

// File: rtl/rise_detect.sv
// Rising-edge detector: one previous-sample flop, pulse while sig is high and was low.
module rise_detect (
  input  logic clk,
  input  logic reset,
  input  logic sig,
  output logic rise
);

  logic prev_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_q <= 1'b0;
    end else begin
      prev_q <= sig;
    end
  end

  assign rise = sig & ~prev_q;

endmodule

// File: rtl/miss_tracker.sv
// Miss bookkeeping: saturating miss count, hit-streak restore, flash timer and
// IDLE/PLAY/OVER game state, all outputs registered.
module miss_tracker
  import miss_pkg::*;
#(
  parameter int unsigned FLASH_CYCLES = 25_000_000,
  parameter int unsigned STREAK_LEN   = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              miss_event,
  input  logic              hit_event,
  output logic [MISS_W-1:0] miss,
  output logic              game_over,
  output logic              miss_flash,
  output logic              playing
);

  localparam int unsigned STREAK_W = $clog2(STREAK_LEN + 1);
  localparam int unsigned FLASH_W  = $clog2(FLASH_CYCLES + 1);

  logic miss_rise, hit_rise;

  rise_detect u_miss_rise (
    .clk   (clk),
    .reset (reset),
    .sig   (miss_event),
    .rise  (miss_rise)
  );

  rise_detect u_hit_rise (
    .clk   (clk),
    .reset (reset),
    .sig   (hit_event),
    .rise  (hit_rise)
  );

  miss_state_t         state_q, state_d;
  logic [MISS_W-1:0]   count_q, count_d;
  logic [STREAK_W-1:0] streak_q, streak_d;
  logic [FLASH_W-1:0]  flash_q, flash_d;
  logic                game_over_q, playing_q, flash_on_q;

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    streak_d = streak_q;
    flash_d  = (flash_q != '0) ? flash_q - 1'b1 : '0;
    unique case (state_q)
      IDLE, OVER: begin
        if (start) begin
          state_d  = PLAY;
          count_d  = '0;
          streak_d = '0;
          flash_d  = '0;
        end
      end
      PLAY: begin
        if (start) begin
          count_d  = '0;
          streak_d = '0;
          flash_d  = '0;
        end else if (miss_rise) begin
          // A hit rising in the same cycle is dropped in favour of the miss.
          count_d  = count_q + 1'b1;
          streak_d = '0;
          flash_d  = FLASH_W'(FLASH_CYCLES);
          if (count_q + 1'b1 == MAX_MISS) state_d = OVER;
        end else if (hit_rise) begin
          if (streak_q == STREAK_W'(STREAK_LEN - 1)) begin
            streak_d = '0;
            if (count_q != '0) count_d = count_q - 1'b1;
          end else begin
            streak_d = streak_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      count_q     <= '0;
      streak_q    <= '0;
      flash_q     <= '0;
      game_over_q <= 1'b0;
      playing_q   <= 1'b0;
      flash_on_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      streak_q    <= streak_d;
      flash_q     <= flash_d;
      game_over_q <= (state_d == OVER);
      playing_q   <= (state_d == PLAY);
      flash_on_q  <= (flash_d != '0);
    end
  end

  assign miss       = count_q;
  assign game_over  = game_over_q;
  assign playing    = playing_q;
  assign miss_flash = flash_on_q;

endmodule

// File: tb/tb_miss_tracker.sv
// Directed self-checking bench for miss_tracker with FLASH_CYCLES=4, STREAK_LEN=3.
module tb_miss_tracker;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       miss_event = 1'b0;
  logic       hit_event = 1'b0;
  logic [1:0] miss;
  logic       game_over, miss_flash, playing;

  int checks = 0;
  int errors = 0;

  miss_tracker #(
    .FLASH_CYCLES (4),
    .STREAK_LEN   (3)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .miss_event (miss_event),
    .hit_event  (hit_event),
    .miss       (miss),
    .game_over  (game_over),
    .miss_flash (miss_flash),
    .playing    (playing)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic hit_pulse();
    hit_event = 1'b1;
    tick();
    hit_event = 1'b0;
    tick();
  endtask

  task automatic miss_pulse();
    miss_event = 1'b1;
    tick();
    miss_event = 1'b0;
    tick();
  endtask

  task automatic new_game();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #2;
    checks++;
    if (miss !== 2'd0) begin errors++; $display("FAIL reset_miss got %0d want 0", miss); end
    checks++;
    if (game_over !== 1'b0) begin errors++; $display("FAIL reset_over got %b want 0", game_over); end
    checks++;
    if (miss_flash !== 1'b0) begin errors++; $display("FAIL reset_flash got %b want 0", miss_flash); end
    checks++;
    if (playing !== 1'b0) begin errors++; $display("FAIL reset_playing got %b want 0", playing); end
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (playing !== 1'b1) begin errors++; $display("FAIL start_playing got %b want 1", playing); end
    checks++;
    if ({miss, game_over, miss_flash} !== 4'b0) begin
      errors++;
      $display("FAIL start_outputs got miss=%0d over=%b flash=%b want 0 0 0",
               miss, game_over, miss_flash);
    end
    tick();
  endtask

  task automatic test_miss_to_over();
    for (int i = 1; i <= 3; i++) begin
      miss_event = 1'b1;
      tick();
      miss_event = 1'b0;
      checks++;
      if (miss !== 2'(i)) begin errors++; $display("FAIL miss_count got %0d want %0d", miss, i); end
      checks++;
      if (miss_flash !== 1'b1) begin errors++; $display("FAIL flash_start%0d got %b want 1", i, miss_flash); end
      checks++;
      if (game_over !== (i == 3)) begin
        errors++; $display("FAIL over_at%0d got %b want %b", i, game_over, (i == 3));
      end
      checks++;
      if (playing !== (i != 3)) begin
        errors++; $display("FAIL playing_at%0d got %b want %b", i, playing, (i != 3));
      end
      for (int j = 1; j <= 3; j++) begin
        tick();
        checks++;
        if (miss_flash !== 1'b1) begin errors++; $display("FAIL flash_hold%0d_%0d got %b want 1", i, j, miss_flash); end
      end
      tick();
      checks++;
      if (miss_flash !== 1'b0) begin errors++; $display("FAIL flash_end%0d got %b want 0", i, miss_flash); end
      tick();
    end
    miss_pulse();
    hit_pulse();
    hit_pulse();
    hit_pulse();
    checks++;
    if (miss !== 2'd3) begin errors++; $display("FAIL over_frozen got %0d want 3", miss); end
    checks++;
    if (game_over !== 1'b1 || miss_flash !== 1'b0) begin
      errors++; $display("FAIL over_state got over=%b flash=%b want 1 0", game_over, miss_flash);
    end
  endtask

  task automatic test_streak();
    new_game();
    checks++;
    if (miss !== 2'd0 || playing !== 1'b1) begin
      errors++; $display("FAIL restart got miss=%0d playing=%b want 0 1", miss, playing);
    end
    miss_pulse();
    miss_pulse();
    hit_pulse();
    hit_pulse();
    checks++;
    if (miss !== 2'd2) begin errors++; $display("FAIL streak_partial got %0d want 2", miss); end
    hit_event = 1'b1;
    tick();
    hit_event = 1'b0;
    checks++;
    if (miss !== 2'd1) begin errors++; $display("FAIL streak_restore got %0d want 1", miss); end
    tick();
    hit_pulse();
    hit_pulse();
    hit_pulse();
    checks++;
    if (miss !== 2'd0) begin errors++; $display("FAIL streak_to_zero got %0d want 0", miss); end
    hit_pulse();
    hit_pulse();
    hit_pulse();
    checks++;
    if (miss !== 2'd0) begin errors++; $display("FAIL streak_floor got %0d want 0", miss); end
  endtask

  task automatic test_same_cycle();
    new_game();
    miss_pulse();
    hit_pulse();
    hit_pulse();
    miss_event = 1'b1;
    hit_event  = 1'b1;
    tick();
    miss_event = 1'b0;
    hit_event  = 1'b0;
    checks++;
    if (miss !== 2'd2) begin errors++; $display("FAIL same_cycle got %0d want 2", miss); end
    tick();
    hit_pulse();
    hit_pulse();
    checks++;
    if (miss !== 2'd2) begin errors++; $display("FAIL streak_cleared got %0d want 2", miss); end
    hit_pulse();
    checks++;
    if (miss !== 2'd1) begin errors++; $display("FAIL streak_after_clear got %0d want 1", miss); end
  endtask

  task automatic test_held_level();
    new_game();
    miss_event = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    miss_event = 1'b0;
    tick();
    checks++;
    if (miss !== 2'd1) begin errors++; $display("FAIL held_level got %0d want 1", miss); end
  endtask

  task automatic test_start_held();
    new_game();
    start = 1'b1;
    tick();
    miss_pulse();
    hit_pulse();
    checks++;
    if (miss !== 2'd0 || miss_flash !== 1'b0) begin
      errors++; $display("FAIL start_held got miss=%0d flash=%b want 0 0", miss, miss_flash);
    end
    start = 1'b0;
    tick();
    miss_pulse();
    checks++;
    if (miss !== 2'd1) begin errors++; $display("FAIL after_start_drop got %0d want 1", miss); end
  endtask

  task automatic test_reset_mid();
    new_game();
    miss_pulse();
    miss_event = 1'b1;
    tick();
    miss_event = 1'b0;
    checks++;
    if (miss !== 2'd2 || miss_flash !== 1'b1) begin
      errors++; $display("FAIL pre_reset got miss=%0d flash=%b want 2 1", miss, miss_flash);
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if ({miss, game_over, miss_flash, playing} !== 5'b0) begin
      errors++;
      $display("FAIL async_reset got miss=%0d over=%b flash=%b playing=%b want 0 0 0 0",
               miss, game_over, miss_flash, playing);
    end
    tick();
    reset = 1'b0;
    tick();
    miss_pulse();
    checks++;
    if (miss !== 2'd0 || playing !== 1'b0 || miss_flash !== 1'b0) begin
      errors++;
      $display("FAIL idle_ignores got miss=%0d playing=%b flash=%b want 0 0 0",
               miss, playing, miss_flash);
    end
  endtask

  initial begin
    test_reset();
    test_start();
    test_miss_to_over();
    test_streak();
    test_same_cycle();
    test_held_level();
    test_start_held();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
